// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for a shared main-memory port.
// Requester 0 is the L1 instruction cache, requester 1 the L1 data cache.
// The owner's command, address and write data are forwarded combinationally to
// memory; mem_ready/mem_rdata are routed back only to the current owner.
// Every transaction ends with one IDLE cycle, so a requester issuing back-to-back
// commands (writeback then refill) yields to a waiting peer in between.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound each grant to TIMEOUT
// cycles. On expiry the owner gets a ready pulse with zero data and timeout_err
// pulses for one cycle. Without the macro a grant waits indefinitely.

module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_read,
    input  logic                  req0_write,
    input  logic [DATA_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_read,
    input  logic                  req1_write,
    input  logic [DATA_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [1:0]            grant,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   rr_r;
    logic   rr_nxt_s;
    logic   act0_s;
    logic   act1_s;
    logic   timeout_s;

    assign act0_s = req0_read | req0_write;
    assign act1_s = req1_read | req1_write;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_r;

    // Grant-age counter: held at zero in IDLE so it is clear on every grant entry,
    // then counts each granted cycle that passes without mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == IDLE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!mem_ready) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry fires in the cycle the count would reach TIMEOUT; mem_ready on that
    // same cycle takes precedence and completes normally.
    always_comb begin
        timeout_s = 1'b0;
        if ((state_r != IDLE) && !mem_ready && (cnt_r == CNT_W'(TIMEOUT - 1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end
`else
    // Without the timeout feature a grant only ends on mem_ready.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // State and round-robin pointer registers; async reset abandons any grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, release the grant on completion or expiry
    // and hand preference to the other requester.
    always_comb begin
        state_nxt_s = state_r;
        rr_nxt_s    = rr_r;
        case (state_r)
            IDLE: begin
                if (act0_s && act1_s) begin
                    state_nxt_s = rr_r ? GRANT1 : GRANT0;
                end else if (act0_s) begin
                    state_nxt_s = GRANT0;
                end else if (act1_s) begin
                    state_nxt_s = GRANT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT0: begin
                if (mem_ready || timeout_s) begin
                    state_nxt_s = IDLE;
                    rr_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = GRANT0;
                end
            end
            GRANT1: begin
                if (mem_ready || timeout_s) begin
                    state_nxt_s = IDLE;
                    rr_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = GRANT1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                rr_nxt_s    = 1'b0;
            end
        endcase
    end

    // Grant is a pure decode of the state register, so it is one-hot or zero.
    always_comb begin
        grant = 2'b00;
        case (state_r)
            GRANT0:  grant = 2'b01;
            GRANT1:  grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Datapath mux: mirror the owner's command to memory and route the response
    // back only to the owner. A simultaneous read+write forwards the write alone.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = {DATA_WIDTH{1'b0}};
        mem_wdata   = {DATA_WIDTH{1'b0}};
        req0_ready  = 1'b0;
        req0_rdata  = {DATA_WIDTH{1'b0}};
        req1_ready  = 1'b0;
        req1_rdata  = {DATA_WIDTH{1'b0}};
        timeout_err = timeout_s;
        case (state_r)
            GRANT0: begin
                mem_read   = req0_read & ~req0_write;
                mem_write  = req0_write;
                mem_addr   = act0_s ? req0_addr : {DATA_WIDTH{1'b0}};
                mem_wdata  = act0_s ? req0_wdata : {DATA_WIDTH{1'b0}};
                req0_ready = mem_ready | timeout_s;
                req0_rdata = timeout_s ? {DATA_WIDTH{1'b0}} : mem_rdata;
            end
            GRANT1: begin
                mem_read   = req1_read & ~req1_write;
                mem_write  = req1_write;
                mem_addr   = act1_s ? req1_addr : {DATA_WIDTH{1'b0}};
                mem_wdata  = act1_s ? req1_wdata : {DATA_WIDTH{1'b0}};
                req1_ready = mem_ready | timeout_s;
                req1_rdata = timeout_s ? {DATA_WIDTH{1'b0}} : mem_rdata;
            end
            default: begin
                mem_read    = 1'b0;
                mem_write   = 1'b0;
                timeout_err = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT overridden to 4).
// Inputs change 1 time unit after a rising edge; outputs are checked on the
// following falling edge.

module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_read, req0_write, req0_ready;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic        req1_read, req1_write, req1_ready;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic        mem_read, mem_write, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks;
    int errors;

    mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_read(req0_read), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req1_read(req1_read), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // wait for the sampling point of the current cycle
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        req0_read = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_read = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  32'(grant), 32'h0);
        chk({tag, "_mrd"},    32'(mem_read), 32'h0);
        chk({tag, "_mwr"},    32'(mem_write), 32'h0);
        chk({tag, "_maddr"},  mem_addr, 32'h0);
        chk({tag, "_mwdata"}, mem_wdata, 32'h0);
        chk({tag, "_rdy0"},   32'(req0_ready), 32'h0);
        chk({tag, "_rdy1"},   32'(req1_ready), 32'h0);
        chk({tag, "_rdata0"}, req0_rdata, 32'h0);
        chk({tag, "_rdata1"}, req1_rdata, 32'h0);
        chk({tag, "_tmo"},    32'(timeout_err), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr_inputs();
        rst_n = 1'b0;

        // ---- reset, then 5 idle cycles ----
        nxt(); smp();
        chk_all_zero("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nxt(); smp();
        end
        chk_all_zero("idle5");

        // ---- requester 0 read, ready in 3rd grant cycle ----
        nxt(); req0_read = 1'b1; req0_addr = 32'h40; smp();
        chk("a_req_cyc_grant", 32'(grant), 32'h0);
        nxt(); smp();
        chk("a_g1_grant", 32'(grant), 32'h1);
        chk("a_g1_mrd", 32'(mem_read), 32'h1);
        chk("a_g1_maddr", mem_addr, 32'h40);
        chk("a_g1_rdy0", 32'(req0_ready), 32'h0);
        nxt(); smp();
        chk("a_g2_mrd", 32'(mem_read), 32'h1);
        chk("a_g2_maddr", mem_addr, 32'h40);
        nxt(); mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; smp();
        chk("a_g3_mrd", 32'(mem_read), 32'h1);
        chk("a_g3_rdy0", 32'(req0_ready), 32'h1);
        chk("a_g3_rdata0", req0_rdata, 32'hDEADBEEF);
        chk("a_g3_rdy1", 32'(req1_ready), 32'h0);
        chk("a_g3_rdata1", req1_rdata, 32'h0);
        nxt(); clr_inputs(); smp();
        chk("a_after_grant", 32'(grant), 32'h0);

        // ---- async reset in the middle of a grant (also returns rr to 0) ----
        nxt(); req1_read = 1'b1; req1_addr = 32'h80; smp();
        nxt(); smp();
        chk("r_grant1", 32'(grant), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("r_async_grant", 32'(grant), 32'h0);
        chk("r_async_mrd", 32'(mem_read), 32'h0);
        chk("r_async_maddr", mem_addr, 32'h0);
        nxt(); clr_inputs(); rst_n = 1'b1; smp();
        chk("r_after_grant", 32'(grant), 32'h0);

        // ---- both read together: requester 0 first, then requester 1 ----
        nxt(); req0_read = 1'b1; req0_addr = 32'h100; req1_read = 1'b1; req1_addr = 32'h200; smp();
        nxt(); smp();
        chk("b_g0_grant", 32'(grant), 32'h1);
        chk("b_g0_maddr", mem_addr, 32'h100);
        chk("b_g0_rdy1", 32'(req1_ready), 32'h0);
        nxt(); mem_ready = 1'b1; mem_rdata = 32'hAAAA0000; smp();
        chk("b_g0_rdy0", 32'(req0_ready), 32'h1);
        chk("b_g0_rdy1_at_ready", 32'(req1_ready), 32'h0);
        chk("b_g0_rdata1", req1_rdata, 32'h0);
        nxt(); req0_read = 1'b0; mem_ready = 1'b0; smp();
        chk("b_idle_gap", 32'(grant), 32'h0);
        nxt(); smp();
        chk("b_g1_grant", 32'(grant), 32'h2);
        chk("b_g1_maddr", mem_addr, 32'h200);
        chk("b_g1_mrd", 32'(mem_read), 32'h1);
        nxt(); mem_ready = 1'b1; mem_rdata = 32'h00000055; smp();
        chk("b_g1_rdy1", 32'(req1_ready), 32'h1);
        chk("b_g1_rdata1", req1_rdata, 32'h55);
        chk("b_g1_rdy0", 32'(req0_ready), 32'h0);
        chk("b_g1_rdata0", req0_rdata, 32'h0);
        nxt(); clr_inputs(); smp();
        chk("b_after", 32'(grant), 32'h0);

        // ---- requester 1 writeback then refill; requester 0 cuts in ----
        nxt(); req1_write = 1'b1; req1_addr = 32'h300; req1_wdata = 32'h12345678; smp();
        nxt(); req0_read = 1'b1; req0_addr = 32'h40; smp();
        chk("w_wb_grant", 32'(grant), 32'h2);
        chk("w_wb_mwr", 32'(mem_write), 32'h1);
        chk("w_wb_mrd", 32'(mem_read), 32'h0);
        chk("w_wb_wdata", mem_wdata, 32'h12345678);
        nxt(); mem_ready = 1'b1; smp();
        chk("w_wb_rdy1", 32'(req1_ready), 32'h1);
        nxt(); mem_ready = 1'b0; req1_write = 1'b0; req1_read = 1'b1; smp();
        chk("w_idle_gap", 32'(grant), 32'h0);
        nxt(); mem_ready = 1'b1; mem_rdata = 32'h00000011; smp();
        chk("w_r0_grant", 32'(grant), 32'h1);
        chk("w_r0_maddr", mem_addr, 32'h40);
        chk("w_r0_rdata0", req0_rdata, 32'h11);
        nxt(); req0_read = 1'b0; mem_ready = 1'b0; smp();
        chk("w_idle_gap2", 32'(grant), 32'h0);
        nxt(); mem_ready = 1'b1; mem_rdata = 32'h00000022; smp();
        chk("w_refill_grant", 32'(grant), 32'h2);
        chk("w_refill_mrd", 32'(mem_read), 32'h1);
        chk("w_refill_maddr", mem_addr, 32'h300);
        chk("w_refill_rdata1", req1_rdata, 32'h22);
        nxt(); clr_inputs(); smp();
        chk("w_after", 32'(grant), 32'h0);

        // ---- read+write together, then illegal request drop mid-grant ----
        nxt(); req0_read = 1'b1; req0_write = 1'b1; req0_addr = 32'h500; req0_wdata = 32'h0BADF00D; smp();
        nxt(); smp();
        chk("rw_grant", 32'(grant), 32'h1);
        chk("rw_mwr", 32'(mem_write), 32'h1);
        chk("rw_mrd", 32'(mem_read), 32'h0);
        chk("rw_wdata", mem_wdata, 32'h0BADF00D);
        nxt(); req0_read = 1'b0; req0_write = 1'b0; smp();
        chk("drop_grant_held", 32'(grant), 32'h1);
        chk("drop_mwr", 32'(mem_write), 32'h0);
        chk("drop_maddr", mem_addr, 32'h0);
        chk("drop_wdata", mem_wdata, 32'h0);
        nxt(); req0_write = 1'b1; mem_ready = 1'b1; smp();
        chk("rw_rdy0", 32'(req0_ready), 32'h1);
        nxt(); clr_inputs(); smp();
        chk("rw_after", 32'(grant), 32'h0);

        // ---- requester 0 read with mem_ready held low, requester 1 waiting ----
        nxt(); req0_read = 1'b1; req0_addr = 32'h600; mem_rdata = 32'hFFFFFFFF; smp();
        nxt(); req1_read = 1'b1; req1_addr = 32'h700; smp();
        chk("t_c1_grant", 32'(grant), 32'h1);
        chk("t_c1_tmo", 32'(timeout_err), 32'h0);
        nxt(); smp();
        nxt(); smp();
        chk("t_c3_tmo", 32'(timeout_err), 32'h0);
        chk("t_c3_rdy0", 32'(req0_ready), 32'h0);
        nxt(); smp();
`ifdef MEM_ARB_TIMEOUT_EN
        chk("t_c4_tmo", 32'(timeout_err), 32'h1);
        chk("t_c4_rdy0", 32'(req0_ready), 32'h1);
        chk("t_c4_rdata0", req0_rdata, 32'h0);
        chk("t_c4_rdy1", 32'(req1_ready), 32'h0);
        nxt(); req0_read = 1'b0; smp();
        chk("t_idle_grant", 32'(grant), 32'h0);
        chk("t_idle_tmo", 32'(timeout_err), 32'h0);
        nxt(); smp();
        chk("t_next_grant", 32'(grant), 32'h2);
        chk("t_next_maddr", mem_addr, 32'h700);
`else
        chk("t_c4_tmo", 32'(timeout_err), 32'h0);
        chk("t_c4_rdy0", 32'(req0_ready), 32'h0);
        for (int i = 0; i < 6; i++) begin
            nxt(); smp();
        end
        chk("t_long_grant", 32'(grant), 32'h1);
        chk("t_long_tmo", 32'(timeout_err), 32'h0);
        chk("t_long_rdy1", 32'(req1_ready), 32'h0);
        nxt(); mem_ready = 1'b1; mem_rdata = 32'h00000066; smp();
        chk("t_long_rdy0", 32'(req0_ready), 32'h1);
        chk("t_long_rdata0", req0_rdata, 32'h66);
        nxt(); req0_read = 1'b0; mem_ready = 1'b0; smp();
        chk("t_idle_grant", 32'(grant), 32'h0);
        nxt(); smp();
        chk("t_next_grant", 32'(grant), 32'h2);
        chk("t_next_maddr", mem_addr, 32'h700);
`endif
        nxt(); mem_ready = 1'b1; smp();
        chk("t_r1_rdy1", 32'(req1_ready), 32'h1);
        nxt(); clr_inputs(); smp();
        chk_all_zero("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
